// File: rtl/axi_steer_pkg.sv
// Shared types and constants for the AXI write-path steering block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axi_steer_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        AW_FWD,
        DATA,
        RESP
    } state_e;

endpackage

// File: rtl/axi_beat_counter.sv
// W-burst beat counter; flags a sticky error when WLAST disagrees with AWLEN.
// Latency: count and flag update on the clock edge that completes a beat.
// Backpressure: none; counts only beats the parent reports as handshaken.
//
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   beat        : one W beat handshaken this cycle
//   last        : WLAST of that beat
//   len         : captured AWLEN (beats minus one)
//   len_err     : sticky mismatch flag, cleared only by reset
module axi_beat_counter (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       beat,
    input  logic       last,
    input  logic [7:0] len,
    output logic       len_err
);

    logic [7:0] count;

    // The compare uses the pre-increment count, so len=255 matches on the
    // 256th beat before the counter wraps.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count   <= 8'd0;
            len_err <= 1'b0;
        end else if (beat) begin
            count <= last ? 8'd0 : count + 8'd1;
            if ((last && (count != len)) || (!last && (count == len))) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_steer.sv
// AXI write steering: decodes AW to a slave, drives the W demux select, returns B or DECERR.
// Latency: AW accept to first W beat is 2 cycles minimum; one transaction outstanding.
// Backpressure: AW held until the slave accepts; W/B ready-valid pass through in DATA/RESP only.
//
// Ports:
//   clk, arst_n                    : clock, asynchronous active-low reset
//   s_aw_* / s_w_* / s_b_*         : master-side AW, W control and B channels
//   m_aw_* / m_w_* / m_b_*         : per-slave one-hot AW/W valids, readies and B channel
//   w_sel                          : W demux select, stable for the whole burst
//   len_err                        : sticky flag, WLAST disagreed with AWLEN
module axi_wr_steer
    import axi_steer_pkg::*;
#(
    parameter int NUM_SLV    = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int REGION_LSB = 12,
    parameter int SEL_W      = $clog2(NUM_SLV) + 1
) (
    input  logic                        clk,
    input  logic                        arst_n,

    input  logic                        s_aw_valid,
    output logic                        s_aw_ready,
    input  logic [ADDR_WIDTH-1:0]       s_aw_addr,
    input  logic [ID_WIDTH-1:0]         s_aw_id,
    input  logic [7:0]                  s_aw_len,

    input  logic                        s_w_valid,
    output logic                        s_w_ready,
    input  logic                        s_w_last,

    output logic [NUM_SLV-1:0]          m_aw_valid,
    input  logic [NUM_SLV-1:0]          m_aw_ready,
    output logic [NUM_SLV-1:0]          m_w_valid,
    input  logic [NUM_SLV-1:0]          m_w_ready,
    output logic [$clog2(NUM_SLV)-1:0]  w_sel,

    input  logic [NUM_SLV-1:0]          m_b_valid,
    output logic [NUM_SLV-1:0]          m_b_ready,
    input  resp_t [NUM_SLV-1:0]         m_b_resp,

    output logic                        s_b_valid,
    input  logic                        s_b_ready,
    output logic [ID_WIDTH-1:0]         s_b_id,
    output resp_t                       s_b_resp,

    output logic                        len_err
);

    localparam int IDX_W = $clog2(NUM_SLV);
    localparam logic [SEL_W-1:0] NUM_SLV_SEL = SEL_W'(NUM_SLV);

    state_e                 state_q;
    logic                   aw_rdy_q;
    logic                   aw_vld_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [7:0]             len_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   dec_err_q;

    logic [SEL_W-1:0]       aw_idx;
    logic                   aw_dec_err;
    logic [NUM_SLV-1:0]     sel_mask;
    logic                   w_hs;
    logic                   b_hs;

    // Only the region field of the address matters for steering.
    logic unused_addr;
    assign unused_addr = ^s_aw_addr;

    // The extra top bit of the index field lets regions beyond the last
    // slave decode as unmapped instead of aliasing onto a real slave.
    assign aw_idx     = s_aw_addr[REGION_LSB +: SEL_W];
    assign aw_dec_err = (aw_idx >= NUM_SLV_SEL);

    assign sel_mask = NUM_SLV'(1) << idx_q;
    assign w_hs     = s_w_valid && s_w_ready;
    assign b_hs     = s_b_valid && s_b_ready;

    assign s_aw_ready = aw_rdy_q;
    assign w_sel      = idx_q;
    assign s_b_id     = id_q;

    // s_aw_ready is a register so it stays low while reset is asserted and
    // rises on the first clock after release.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            aw_rdy_q  <= 1'b0;
            aw_vld_q  <= 1'b0;
            id_q      <= '0;
            len_q     <= 8'd0;
            idx_q     <= '0;
            dec_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_rdy_q && s_aw_valid) begin
                        id_q      <= s_aw_id;
                        len_q     <= s_aw_len;
                        idx_q     <= aw_idx[IDX_W-1:0];
                        dec_err_q <= aw_dec_err;
                        aw_rdy_q  <= 1'b0;
                        if (aw_dec_err) begin
                            state_q <= DATA;
                        end else begin
                            aw_vld_q <= 1'b1;
                            state_q  <= AW_FWD;
                        end
                    end else begin
                        aw_rdy_q <= 1'b1;
                    end
                end
                AW_FWD: begin
                    if (m_aw_ready[idx_q]) begin
                        aw_vld_q <= 1'b0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs && s_w_last) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        aw_rdy_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pass-through paths are gated by the registered state, so nothing on
    // the slave side can react to s_aw_valid within the same cycle.
    always_comb begin
        m_aw_valid = aw_vld_q ? sel_mask : '0;
        m_w_valid  = '0;
        s_w_ready  = 1'b0;
        m_b_ready  = '0;
        s_b_valid  = 1'b0;
        s_b_resp   = RESP_OKAY;
        case (state_q)
            DATA: begin
                if (dec_err_q) begin
                    // Unmapped: swallow the burst so the master can finish.
                    s_w_ready = 1'b1;
                end else begin
                    m_w_valid = sel_mask & {NUM_SLV{s_w_valid}};
                    s_w_ready = m_w_ready[idx_q];
                end
            end
            RESP: begin
                if (dec_err_q) begin
                    s_b_valid = 1'b1;
                    s_b_resp  = RESP_DECERR;
                end else begin
                    s_b_valid = m_b_valid[idx_q];
                    s_b_resp  = m_b_resp[idx_q];
                    m_b_ready = sel_mask & {NUM_SLV{s_b_ready}};
                end
            end
            default: ;
        endcase
    end

    axi_beat_counter u_beat_counter (
        .clk     (clk),
        .arst_n  (arst_n),
        .beat    (w_hs),
        .last    (s_w_last),
        .len     (len_q),
        .len_err (len_err)
    );

endmodule

// File: tb/tb_axi_wr_steer.sv
// Self-checking bench for axi_wr_steer: directed vector table, random
// transactions against an address-decode model, and multi-cycle corner cases.
module tb_axi_wr_steer;

    localparam int NUM_SLV = 8;

    logic              clk;
    logic              arst_n;
    logic              s_aw_valid;
    logic              s_aw_ready;
    logic [31:0]       s_aw_addr;
    logic [3:0]        s_aw_id;
    logic [7:0]        s_aw_len;
    logic              s_w_valid;
    logic              s_w_ready;
    logic              s_w_last;
    logic [7:0]        m_aw_valid;
    logic [7:0]        m_aw_ready;
    logic [7:0]        m_w_valid;
    logic [7:0]        m_w_ready;
    logic [2:0]        w_sel;
    logic [7:0]        m_b_valid;
    logic [7:0]        m_b_ready;
    logic [7:0][1:0]   m_b_resp;
    logic              s_b_valid;
    logic              s_b_ready;
    logic [3:0]        s_b_id;
    logic [1:0]        s_b_resp;
    logic              len_err;

    axi_wr_steer dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .s_aw_valid (s_aw_valid),
        .s_aw_ready (s_aw_ready),
        .s_aw_addr  (s_aw_addr),
        .s_aw_id    (s_aw_id),
        .s_aw_len   (s_aw_len),
        .s_w_valid  (s_w_valid),
        .s_w_ready  (s_w_ready),
        .s_w_last   (s_w_last),
        .m_aw_valid (m_aw_valid),
        .m_aw_ready (m_aw_ready),
        .m_w_valid  (m_w_valid),
        .m_w_ready  (m_w_ready),
        .w_sel      (w_sel),
        .m_b_valid  (m_b_valid),
        .m_b_ready  (m_b_ready),
        .m_b_resp   (m_b_resp),
        .s_b_valid  (s_b_valid),
        .s_b_ready  (s_b_ready),
        .s_b_id     (s_b_id),
        .s_b_resp   (s_b_resp),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        int          nbeats;
        logic [1:0]  sresp;
        int          wmode;
        logic [7:0]  exp_aw;
        logic [2:0]  exp_sel;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [7:0] aw_seen;
        int         w_hs;
        bit         other_w;
        bit         sel_bad;
        bit         sel_valid;
        logic [2:0] sel_seen;
        logic [1:0] resp;
        logic [3:0] bid;
        bit         timeout;
        bit         early_rdy;
        bit         b_drop;
        int         b_cycles;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_aw_valid = 1'b0;
        s_w_valid  = 1'b0;
        s_w_last   = 1'b0;
        m_aw_ready = '0;
        m_w_ready  = '0;
        m_b_valid  = '0;
        s_b_ready  = 1'b0;
    endtask

    // Plays master and slaves for one write; records what the DUT did.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input int nbeats, input logic [1:0] sresp, input int wmode,
                           input int aw_dly, input int b_dly, input bit early_b, output obs_t o);
        int idx, beats, aw_wait, b_wait, cyc;
        bit mapped, b_seen, aw_acc, done, aw_hs, w_hs_now;
        logic [7:0] tmask;
        idx    = int'((addr >> 12) & 32'hF);
        mapped = (idx < NUM_SLV);
        tmask  = mapped ? 8'(1 << idx) : 8'h00;
        o = '{default: 0};
        beats = 0; aw_wait = 0; b_wait = 0; cyc = 0;
        b_seen = 0; aw_acc = 0; done = 0;
        @(posedge clk); #1;
        s_aw_valid = 1'b1;
        s_aw_addr  = addr;
        s_aw_id    = id;
        s_aw_len   = len;
        s_w_valid  = (nbeats > 0);
        s_w_last   = (nbeats == 1);
        m_aw_ready = (aw_dly == 0) ? 8'hFF : 8'h00;
        m_w_ready  = 8'hFF;
        m_b_valid  = '0;
        for (int k = 0; k < NUM_SLV; k++) m_b_resp[k] = (k == idx) ? sresp : ~sresp;
        s_b_ready  = (b_dly == 0);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            o.aw_seen |= m_aw_valid;
            if (m_aw_valid != 0) aw_wait++;
            if ((m_w_valid & ~tmask) != 0) o.other_w = 1;
            if (((m_b_ready & ~tmask) != 0) || (beats < nbeats && m_b_ready != 0)) o.early_rdy = 1;
            w_hs_now = s_w_valid && s_w_ready;
            if (mapped ? ((m_w_valid & m_w_ready & tmask) != 0) : w_hs_now) o.w_hs++;
            if (w_hs_now && mapped) begin
                if (!o.sel_valid) begin
                    o.sel_seen  = w_sel;
                    o.sel_valid = 1;
                end else if (w_sel != o.sel_seen) begin
                    o.sel_bad = 1;
                end
            end
            if (b_seen && !s_b_valid) o.b_drop = 1;
            if (s_b_valid) begin
                b_seen = 1;
                o.b_cycles++;
            end
            if (s_b_valid && s_b_ready) begin
                o.resp = s_b_resp;
                o.bid  = s_b_id;
                done   = 1;
            end
            aw_hs = s_aw_valid && s_aw_ready;
            @(posedge clk); #1;
            if (aw_hs) begin
                s_aw_valid = 1'b0;
                aw_acc = 1;
            end
            if (w_hs_now) begin
                beats++;
                s_w_valid = (beats < nbeats);
                s_w_last  = (beats == nbeats - 1);
            end
            if (aw_wait >= aw_dly) m_aw_ready = 8'hFF;
            if (wmode == 1) m_w_ready = ~m_w_ready;
            m_b_valid = (mapped && (early_b ? aw_acc : (beats >= nbeats))) ? tmask : 8'h00;
            if (b_seen) b_wait++;
            if (b_wait >= b_dly) s_b_ready = 1'b1;
            if (done) idle_inputs();
        end
        o.timeout = !done;
        if (!done) idle_inputs();
    endtask

    task automatic check_txn(input string tag, input obs_t o, input logic [7:0] exp_aw, input int exp_hs,
                             input logic [1:0] exp_resp, input logic [3:0] exp_id,
                             input bit chk_sel, input logic [2:0] exp_sel);
        chk({tag, ".timeout"}, o.timeout, 0);
        chk({tag, ".aw_valid"}, o.aw_seen, exp_aw);
        chk({tag, ".w_beats"}, o.w_hs, exp_hs);
        chk({tag, ".bresp"}, o.resp, exp_resp);
        chk({tag, ".bid"}, o.bid, exp_id);
        chk({tag, ".stray_w_valid"}, o.other_w, 0);
        chk({tag, ".b_ready_early"}, o.early_rdy, 0);
        chk({tag, ".b_valid_drop"}, o.b_drop, 0);
        if (chk_sel) begin
            chk({tag, ".w_sel"}, o.sel_seen, exp_sel);
            chk({tag, ".w_sel_stable"}, o.sel_bad, 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        obs_t o;
        int idx;
        logic [31:0] addr;
        logic [7:0] len, exp_aw;
        logic [3:0] id;
        logic [1:0] sresp, exp_resp;
        bit mapped, got;

        vecs[0] = '{32'h0000_3000, 4'h5, 8'd0,   1,   2'b00, 0, 8'h08, 3'd3, 2'b00};
        vecs[1] = '{32'h0000_5000, 4'hA, 8'd3,   4,   2'b00, 1, 8'h20, 3'd5, 2'b00};
        vecs[2] = '{32'h0000_8000, 4'h2, 8'd1,   2,   2'b00, 0, 8'h00, 3'd0, 2'b11};
        vecs[3] = '{32'h0001_7ABC, 4'h7, 8'd2,   3,   2'b10, 1, 8'h80, 3'd7, 2'b10};
        vecs[4] = '{32'h0000_F000, 4'h3, 8'd0,   1,   2'b00, 0, 8'h00, 3'd0, 2'b11};
        vecs[5] = '{32'h0000_0000, 4'hC, 8'd7,   8,   2'b01, 0, 8'h01, 3'd0, 2'b01};
        vecs[6] = '{32'h0000_1000, 4'h1, 8'd255, 256, 2'b00, 0, 8'h02, 3'd1, 2'b00};

        s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0; m_b_resp = '0;
        idle_inputs();
        arst_n = 1'b0;
        #1;
        chk("reset.s_aw_ready", s_aw_ready, 0);
        chk("reset.m_aw_valid", m_aw_valid, 0);
        chk("reset.m_w_valid", m_w_valid, 0);
        chk("reset.s_b_valid", s_b_valid, 0);
        chk("reset.w_sel", w_sel, 0);
        chk("reset.len_err", len_err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) arst_n = 1'b1;

        // Directed vectors; the 4-beat slave-5 entry toggles m_w_ready.
        foreach (vecs[i]) begin
            run_txn(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].nbeats, vecs[i].sresp,
                    vecs[i].wmode, i % 3, i % 2, 1'b0, o);
            check_txn($sformatf("vec%0d", i), o, vecs[i].exp_aw, vecs[i].nbeats, vecs[i].exp_resp,
                      vecs[i].id, vecs[i].exp_aw != 0, vecs[i].exp_sel);
        end
        chk("vec.len_err", len_err, 0);

        // Random well-formed writes against the address-decode model.
        for (int t = 0; t < 40; t++) begin
            idx    = $urandom_range(0, 15);
            addr   = ($urandom & 32'hFFFF_0FFF) | (32'(idx) << 12);
            len    = 8'($urandom_range(0, 7));
            id     = 4'($urandom);
            sresp  = 2'($urandom);
            mapped = (idx < NUM_SLV);
            exp_aw   = mapped ? 8'(1 << idx) : 8'h00;
            exp_resp = mapped ? sresp : 2'b11;
            run_txn(addr, id, len, int'(len) + 1, sresp, int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), o);
            check_txn($sformatf("rnd%0d", t), o, exp_aw, int'(len) + 1, exp_resp, id, mapped, 3'(idx));
        end
        chk("rnd.len_err", len_err, 0);

        // WLAST on beat 2 of a len=3 burst: burst ends early, error is sticky.
        run_txn(32'h0000_6000, 4'h9, 8'd3, 2, 2'b00, 0, 0, 0, 1'b0, o);
        check_txn("short", o, 8'h40, 2, 2'b00, 4'h9, 1'b1, 3'd6);
        chk("short.len_err", len_err, 1);
        run_txn(32'h0000_4000, 4'h4, 8'd1, 2, 2'b00, 0, 1, 1, 1'b0, o);
        check_txn("after_short", o, 8'h10, 2, 2'b00, 4'h4, 1'b1, 3'd4);
        chk("after_short.len_err", len_err, 1);

        // Reset in the middle of a slave-2 burst.
        @(posedge clk); #1;
        s_aw_valid = 1'b1; s_aw_addr = 32'h0000_2000; s_aw_id = 4'h6; s_aw_len = 8'd3;
        s_w_valid = 1'b1; s_w_last = 1'b0; m_aw_ready = 8'hFF; m_w_ready = 8'hFF;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_w_valid[2]) got = 1;
            if (s_aw_valid && s_aw_ready) begin
                @(posedge clk); #1;
                s_aw_valid = 1'b0;
            end
        end
        chk("mid_rst.reached_data", got, 1);
        @(posedge clk); #3;
        arst_n = 1'b0;
        #1;
        chk("mid_rst.m_w_valid", m_w_valid, 0);
        chk("mid_rst.m_aw_valid", m_aw_valid, 0);
        chk("mid_rst.s_w_ready", s_w_ready, 0);
        chk("mid_rst.s_b_valid", s_b_valid, 0);
        chk("mid_rst.m_b_ready", m_b_ready, 0);
        chk("mid_rst.s_aw_ready", s_aw_ready, 0);
        chk("mid_rst.w_sel", w_sel, 0);
        chk("mid_rst.len_err", len_err, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) arst_n = 1'b1;
        run_txn(32'h0000_4000, 4'hB, 8'd1, 2, 2'b01, 0, 0, 0, 1'b0, o);
        check_txn("post_rst", o, 8'h10, 2, 2'b01, 4'hB, 1'b1, 3'd4);

        // Count reaches len without WLAST: flagged, burst runs on to WLAST.
        run_txn(32'h0000_3000, 4'h8, 8'd1, 3, 2'b00, 0, 0, 0, 1'b0, o);
        check_txn("long", o, 8'h08, 3, 2'b00, 4'h8, 1'b1, 3'd3);
        chk("long.len_err", len_err, 1);

        // Slave B raised during DATA, master holds s_b_ready low for 5 cycles.
        run_txn(32'h0000_1000, 4'hD, 8'd1, 2, 2'b10, 1, 0, 5, 1'b1, o);
        check_txn("early_b", o, 8'h02, 2, 2'b10, 4'hD, 1'b1, 3'd1);
        chk("early_b.b_valid_cycles", o.b_cycles, 6);
        @(negedge clk);
        chk("early_b.idle_aw_ready", s_aw_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
